ddr4_out_lane_ctrl: RTL and testbench
=====================================

# ddr4_out_lane_ctrl

Fabric-side controller for a group of output-only DDR4 IOD lanes such as RESET_N, CKE and ODT, at a 4:1 serialisation ratio. It generalises the single-pin wrapper to NUM_LANES pins. It registers per-lane level and output-enable requests into TX_DATA/OE_DATA nibbles. It also runs a request/acknowledge state machine that steps or reloads one lane's dynamic delay line, tracking the tap position and handling out-of-range.

## Interface

Parameters:
- NUM_LANES, 4, number of IOD output lanes controlled (1..16)
- TAP_W, 8, width of the per-lane tap position and step-count fields
- MAX_TAP, 127, highest legal tap position
- INIT_TAP, 1, tap position after reset or a LOAD (matches IOD TX_DELAY_VAL)
- SETTLE_CYCLES, 4, FAB_CLK cycles waited after each MOVE/LOAD pulse (>=1)
- OE_RST, 1, OE value driven by every lane during and after reset

Ports:
- FAB_CLK  in  1  fabric clock; all logic is on this clock
- ARST  in  1  asynchronous, active-high reset
- LANE_LVL  in  NUM_LANES  requested pin level per lane
- LANE_OE  in  NUM_LANES  requested output enable per lane
- TX_DATA  out  4*NUM_LANES  nibble per lane, lane n at [4n+3:4n]
- OE_DATA  out  4*NUM_LANES  OE nibble per lane, same packing
- ADJ_REQ  in  1  start an adjust operation (level, sampled in IDLE)
- ADJ_LOAD  in  1  1 = reload the delay line to preset; 0 = step it
- ADJ_LANE  in  4  target lane index
- ADJ_DIR  in  1  step direction, 1 = increment taps
- ADJ_TAPS  in  TAP_W  number of steps to take
- ADJ_BUSY  out  1  operation in progress
- ADJ_DONE  out  1  one-cycle completion pulse
- ADJ_ERR  out  1  qualifies ADJ_DONE; operation aborted
- DELAY_LINE_MOVE  out  NUM_LANES  per-lane move pulse to IOD
- DELAY_LINE_DIRECTION  out  NUM_LANES  per-lane direction to IOD
- DELAY_LINE_LOAD  out  NUM_LANES  per-lane load pulse to IOD
- DELAY_LINE_OUT_OF_RANGE  in  NUM_LANES  per-lane range flag from IOD
- TAP_POS  out  TAP_W*NUM_LANES  tracked tap position per lane

## Operation

Lane datapath:
- TX_DATA nibble for lane n = {4{LANE_LVL[n]}}, registered.
- OE_DATA nibble for lane n = {4{LANE_OE[n]}}, registered.
- Reset values: TX_DATA=0, so RESET_N is held low; OE_DATA = all bits OE_RST.

Adjust FSM states: IDLE, SETUP, PULSE, SETTLE, DONE.
- **IDLE**
  - ADJ_REQ=1 and ADJ_LANE>=NUM_LANES: go to DONE with ERR.
  - ADJ_REQ=1 otherwise: latch LANE, LOAD, DIR and TAPS into the step counter, then go to SETUP.
- **SETUP**
  - Drive DELAY_LINE_DIRECTION[lane]=DIR; it is held until DONE.
  - TAPS=0 and not LOAD: go to DONE (no pulses).
  - Step would leave 0..MAX_TAP: go to DONE with ERR, and emit no pulse.
  - Otherwise: go to PULSE.
- **PULSE**: one-cycle DELAY_LINE_LOAD[lane] pulse if LOAD, otherwise one-cycle DELAY_LINE_MOVE[lane] pulse; go to SETTLE.
- **SETTLE**
  - Count SETTLE_CYCLES cycles.
  - On the last cycle, sample OUT_OF_RANGE[lane]. If it is 1: TAP_POS is unchanged; go to DONE with ERR.
  - Else, LOAD: TAP_POS[lane]=INIT_TAP; go to DONE.
  - Else, step: TAP_POS[lane] ±1 and decrement the step counter. If the counter reaches 0, go to DONE; otherwise re-run the range check and go to PULSE, or go to DONE with ERR.
- **DONE**: ADJ_DONE=1 and ADJ_ERR valid for one cycle; return to IDLE.
- ADJ_BUSY=1 in every state except IDLE.
- ADJ_REQ is ignored while busy.
- Lanes not addressed keep MOVE/LOAD=0 and DIRECTION=0.

Reset state:
- FSM in IDLE.
- All handshake and IOD strobe outputs are 0.
- Every TAP_POS = INIT_TAP.
- Assertion mid-operation aborts immediately, with no DONE pulse.

## Timing

- Lane datapath latency: 1 cycle from LANE_LVL/LANE_OE to TX_DATA/OE_DATA.
- Handshake timing, with ADJ_REQ sampled at cycle 0:
  - ADJ_BUSY=1 from cycle 1.
  - The first pulse is in cycle 2.
- A step of N>0 taps:
  - ADJ_DONE at cycle 2+N*(1+SETTLE_CYCLES).
  - MOVE pulses are (1+SETTLE_CYCLES) apart.
- LOAD: ADJ_DONE at cycle 2+1+SETTLE_CYCLES.
- TAPS=0, range error or bad lane index: ADJ_DONE at cycle 2 (bad lane index: cycle 1).
- TAP_POS updates on the last SETTLE cycle and is valid on the ADJ_DONE cycle.
- Earliest next request: ADJ_REQ sampled in the cycle after ADJ_DONE.

## Test plan

- **Reset:** assert ARST mid-stream → TX_DATA=0, OE_DATA=all 1s (OE_RST=1), TAP_POS=1 on all lanes, BUSY/DONE/MOVE=0.
- **Lane datapath:** LANE_LVL=4'b1010, LANE_OE=4'b1111 → next cycle TX_DATA=16'hF0F0, OE_DATA=16'hFFFF.
- **Step up:** LANE=2, DIR=1, TAPS=3, SETTLE=4 → three MOVE[2] pulses at cycles 2, 7, 12; DIRECTION[2]=1; DONE at cycle 17, ERR=0, TAP_POS[2]=4.
- **Out of range:** TAPS=5, OUT_OF_RANGE[1]=1 during the second settle → two MOVE pulses, DONE with ERR=1, TAP_POS[1]=INIT_TAP+1.
- **Lower bound:** TAP_POS[0]=1, DIR=0, TAPS=3 → one MOVE pulse (tap becomes 0), then the range check fails; DONE with ERR=1, TAP_POS[0]=0.
- **Load and bad lane:** LOAD on lane 3 after steps → LOAD[3] pulse at cycle 2, TAP_POS[3]=1 at DONE (cycle 7). Separately, ADJ_LANE=5 → DONE+ERR at cycle 1, no strobes.

Source files
------------

// File: rtl/ddr4_out_lane_ctrl.sv
// rtl/ddr4_out_lane_ctrl.sv - fabric-side controller for a group of 4:1 output-only DDR4 IOD lanes
//
// Registers per-lane level/OE requests into TX_DATA/OE_DATA nibbles and runs a
// request/acknowledge FSM that steps or reloads one lane's dynamic delay line,
// tracking the tap position of every lane.
//
// Ports:
//   FAB_CLK, ARST                  clock, asynchronous active-high reset
//   LANE_LVL, LANE_OE              per-lane level / output-enable requests
//   TX_DATA, OE_DATA               registered nibbles, lane n at [4n+3:4n]
//   ADJ_REQ/LOAD/LANE/DIR/TAPS     adjust request and its arguments
//   ADJ_BUSY, ADJ_DONE, ADJ_ERR    adjust handshake
//   DELAY_LINE_MOVE/DIRECTION/LOAD per-lane IOD delay-line controls
//   DELAY_LINE_OUT_OF_RANGE        per-lane range flag from the IOD
//   TAP_POS                        tracked tap position, lane n at [TAP_W*n +: TAP_W]
module ddr4_out_lane_ctrl #(
    parameter int   NUM_LANES     = 4,
    parameter int   TAP_W         = 8,
    parameter int   MAX_TAP       = 127,
    parameter int   INIT_TAP      = 1,
    parameter int   SETTLE_CYCLES = 4,
    parameter logic OE_RST        = 1'b1
) (
    input  logic                       FAB_CLK,
    input  logic                       ARST,
    input  logic [NUM_LANES-1:0]       LANE_LVL,
    input  logic [NUM_LANES-1:0]       LANE_OE,
    output logic [4*NUM_LANES-1:0]     TX_DATA,
    output logic [4*NUM_LANES-1:0]     OE_DATA,
    input  logic                       ADJ_REQ,
    input  logic                       ADJ_LOAD,
    input  logic [3:0]                 ADJ_LANE,
    input  logic                       ADJ_DIR,
    input  logic [TAP_W-1:0]           ADJ_TAPS,
    output logic                       ADJ_BUSY,
    output logic                       ADJ_DONE,
    output logic                       ADJ_ERR,
    output logic [NUM_LANES-1:0]       DELAY_LINE_MOVE,
    output logic [NUM_LANES-1:0]       DELAY_LINE_DIRECTION,
    output logic [NUM_LANES-1:0]       DELAY_LINE_LOAD,
    input  logic [NUM_LANES-1:0]       DELAY_LINE_OUT_OF_RANGE,
    output logic [TAP_W*NUM_LANES-1:0] TAP_POS
);

    localparam int LANE_W = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
    // Settle counter only ever holds SETTLE_CYCLES-1 down to 0.
    localparam int SC_W   = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_PULSE,
        S_SETTLE,
        S_DONE
    } state_t;

    state_t             state;
    logic [LANE_W-1:0]  lane_q;
    logic               load_q;
    logic               dir_q;
    logic [TAP_W-1:0]   steps_q;
    logic [SC_W-1:0]    settle_q;
    logic [TAP_W-1:0]   tap_q [NUM_LANES];

    logic [TAP_W-1:0]     tap_cur;
    logic [TAP_W-1:0]     tap_step;
    logic [NUM_LANES-1:0] lane_sel;
    logic [NUM_LANES-1:0] req_sel;
    logic                 lane_bad;
    logic                 oor_now;

    // True when one more step in direction 'up' would leave 0..MAX_TAP.
    function automatic logic step_blocked(input logic [TAP_W-1:0] tap, input logic up);
        return up ? (tap >= TAP_W'(MAX_TAP)) : (tap == '0);
    endfunction

    assign tap_cur  = tap_q[lane_q];
    assign tap_step = dir_q ? (tap_cur + TAP_W'(1)) : (tap_cur - TAP_W'(1));
    assign lane_sel = NUM_LANES'(1) << lane_q;
    assign req_sel  = NUM_LANES'(1) << ADJ_LANE[LANE_W-1:0];
    assign lane_bad = (int'(ADJ_LANE) >= NUM_LANES);
    assign oor_now  = DELAY_LINE_OUT_OF_RANGE[lane_q];

    for (genvar n = 0; n < NUM_LANES; n++) begin : g_tap_out
        assign TAP_POS[n*TAP_W +: TAP_W] = tap_q[n];
    end

    // Lane datapath: each request bit is replicated across its 4:1 nibble.
    always_ff @(posedge FAB_CLK or posedge ARST) begin
        if (ARST) begin
            TX_DATA <= '0;
            OE_DATA <= {(4*NUM_LANES){OE_RST}};
        end else begin
            for (int n = 0; n < NUM_LANES; n++) begin
                TX_DATA[4*n +: 4] <= {4{LANE_LVL[n]}};
                OE_DATA[4*n +: 4] <= {4{LANE_OE[n]}};
            end
        end
    end

    // Adjust FSM. Strobes and handshake outputs are registered and set on the
    // transition into the state in which they must be visible.
    always_ff @(posedge FAB_CLK or posedge ARST) begin
        if (ARST) begin
            state                <= S_IDLE;
            lane_q               <= '0;
            load_q               <= 1'b0;
            dir_q                <= 1'b0;
            steps_q              <= '0;
            settle_q             <= '0;
            ADJ_BUSY             <= 1'b0;
            ADJ_DONE             <= 1'b0;
            ADJ_ERR              <= 1'b0;
            DELAY_LINE_MOVE      <= '0;
            DELAY_LINE_LOAD      <= '0;
            DELAY_LINE_DIRECTION <= '0;
            for (int n = 0; n < NUM_LANES; n++) begin
                tap_q[n] <= TAP_W'(INIT_TAP);
            end
        end else begin
            DELAY_LINE_MOVE <= '0;
            DELAY_LINE_LOAD <= '0;
            ADJ_DONE        <= 1'b0;
            ADJ_ERR         <= 1'b0;

            case (state)
                S_IDLE: begin
                    if (ADJ_REQ) begin
                        ADJ_BUSY <= 1'b1;
                        if (lane_bad) begin
                            ADJ_DONE <= 1'b1;
                            ADJ_ERR  <= 1'b1;
                            state    <= S_DONE;
                        end else begin
                            lane_q               <= ADJ_LANE[LANE_W-1:0];
                            load_q               <= ADJ_LOAD;
                            dir_q                <= ADJ_DIR;
                            steps_q              <= ADJ_TAPS;
                            DELAY_LINE_DIRECTION <= ADJ_DIR ? req_sel : '0;
                            state                <= S_SETUP;
                        end
                    end
                end

                S_SETUP: begin
                    if (!load_q && steps_q == '0) begin
                        ADJ_DONE <= 1'b1;
                        state    <= S_DONE;
                    end else if (!load_q && step_blocked(tap_cur, dir_q)) begin
                        ADJ_DONE <= 1'b1;
                        ADJ_ERR  <= 1'b1;
                        state    <= S_DONE;
                    end else begin
                        if (load_q) begin
                            DELAY_LINE_LOAD <= lane_sel;
                        end else begin
                            DELAY_LINE_MOVE <= lane_sel;
                        end
                        state <= S_PULSE;
                    end
                end

                S_PULSE: begin
                    settle_q <= SC_W'(SETTLE_CYCLES - 1);
                    state    <= S_SETTLE;
                end

                S_SETTLE: begin
                    if (settle_q != '0) begin
                        settle_q <= settle_q - SC_W'(1);
                    end else if (oor_now) begin
                        ADJ_DONE <= 1'b1;
                        ADJ_ERR  <= 1'b1;
                        state    <= S_DONE;
                    end else if (load_q) begin
                        tap_q[lane_q] <= TAP_W'(INIT_TAP);
                        ADJ_DONE      <= 1'b1;
                        state         <= S_DONE;
                    end else begin
                        tap_q[lane_q] <= tap_step;
                        steps_q       <= steps_q - TAP_W'(1);
                        if (steps_q == TAP_W'(1)) begin
                            ADJ_DONE <= 1'b1;
                            state    <= S_DONE;
                        end else if (step_blocked(tap_step, dir_q)) begin
                            // Range re-check uses the tap this step lands on.
                            ADJ_DONE <= 1'b1;
                            ADJ_ERR  <= 1'b1;
                            state    <= S_DONE;
                        end else begin
                            DELAY_LINE_MOVE <= lane_sel;
                            state           <= S_PULSE;
                        end
                    end
                end

                S_DONE: begin
                    ADJ_BUSY             <= 1'b0;
                    DELAY_LINE_DIRECTION <= '0;
                    state                <= S_IDLE;
                end

                default: begin
                    ADJ_BUSY             <= 1'b0;
                    DELAY_LINE_DIRECTION <= '0;
                    state                <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ddr4_out_lane_ctrl.sv
// tb/tb_ddr4_out_lane_ctrl.sv - scoreboard bench for ddr4_out_lane_ctrl
module tb_ddr4_out_lane_ctrl;

    logic        FAB_CLK = 1'b0;
    logic        ARST;
    logic [3:0]  LANE_LVL;
    logic [3:0]  LANE_OE;
    logic [15:0] TX_DATA;
    logic [15:0] OE_DATA;
    logic        ADJ_REQ;
    logic        ADJ_LOAD;
    logic [3:0]  ADJ_LANE;
    logic        ADJ_DIR;
    logic [7:0]  ADJ_TAPS;
    logic        ADJ_BUSY;
    logic        ADJ_DONE;
    logic        ADJ_ERR;
    logic [3:0]  DELAY_LINE_MOVE;
    logic [3:0]  DELAY_LINE_DIRECTION;
    logic [3:0]  DELAY_LINE_LOAD;
    logic [3:0]  DELAY_LINE_OUT_OF_RANGE;
    logic [31:0] TAP_POS;

    ddr4_out_lane_ctrl #(
        .NUM_LANES(4), .TAP_W(8), .MAX_TAP(127), .INIT_TAP(1),
        .SETTLE_CYCLES(4), .OE_RST(1'b1)
    ) dut (
        .FAB_CLK(FAB_CLK), .ARST(ARST),
        .LANE_LVL(LANE_LVL), .LANE_OE(LANE_OE),
        .TX_DATA(TX_DATA), .OE_DATA(OE_DATA),
        .ADJ_REQ(ADJ_REQ), .ADJ_LOAD(ADJ_LOAD), .ADJ_LANE(ADJ_LANE),
        .ADJ_DIR(ADJ_DIR), .ADJ_TAPS(ADJ_TAPS),
        .ADJ_BUSY(ADJ_BUSY), .ADJ_DONE(ADJ_DONE), .ADJ_ERR(ADJ_ERR),
        .DELAY_LINE_MOVE(DELAY_LINE_MOVE),
        .DELAY_LINE_DIRECTION(DELAY_LINE_DIRECTION),
        .DELAY_LINE_LOAD(DELAY_LINE_LOAD),
        .DELAY_LINE_OUT_OF_RANGE(DELAY_LINE_OUT_OF_RANGE),
        .TAP_POS(TAP_POS)
    );

    always #5 FAB_CLK = ~FAB_CLK;

    typedef struct {
        int         cyc;
        logic [3:0] move;
        logic [3:0] load;
        logic [3:0] dir;
    } pulse_t;

    typedef struct {
        int          cyc;
        logic        err;
        logic [31:0] tap;
    } done_t;

    typedef struct {
        int          cyc;
        logic [15:0] tx;
        logic [15:0] oe;
    } dp_t;

    pulse_t pulse_q[$];
    done_t  done_q[$];
    dp_t    dp_q[$];

    int cyc   = 0;
    int n_cmp = 0;
    int n_err = 0;

    always @(posedge FAB_CLK) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push_pulse(input int c, input logic [3:0] mv, input logic [3:0] ld,
                              input logic [3:0] dr);
        pulse_t p;
        p.cyc = c; p.move = mv; p.load = ld; p.dir = dr;
        pulse_q.push_back(p);
    endtask

    task automatic push_done(input int c, input logic e, input logic [31:0] t);
        done_t d;
        d.cyc = c; d.err = e; d.tap = t;
        done_q.push_back(d);
    endtask

    // Monitor: pops an expectation whenever the DUT presents a strobe or DONE.
    always @(negedge FAB_CLK) begin
        if (!ARST) begin
            if (|DELAY_LINE_MOVE || |DELAY_LINE_LOAD) begin
                if (pulse_q.size() == 0) begin
                    chk("unexpected_pulse", {DELAY_LINE_MOVE, DELAY_LINE_LOAD}, 8'h00);
                end else begin
                    pulse_t p;
                    p = pulse_q.pop_front();
                    chk("pulse_cycle", cyc, p.cyc);
                    chk("pulse_move", DELAY_LINE_MOVE, p.move);
                    chk("pulse_load", DELAY_LINE_LOAD, p.load);
                    chk("pulse_dir", DELAY_LINE_DIRECTION, p.dir);
                end
            end
            if (ADJ_DONE) begin
                if (done_q.size() == 0) begin
                    chk("unexpected_done", ADJ_DONE, 1'b0);
                end else begin
                    done_t d;
                    d = done_q.pop_front();
                    chk("done_cycle", cyc, d.cyc);
                    chk("done_err", ADJ_ERR, d.err);
                    chk("done_tap_pos", TAP_POS, d.tap);
                end
            end
            if (dp_q.size() > 0 && dp_q[0].cyc == cyc) begin
                dp_t e;
                e = dp_q.pop_front();
                chk("tx_data", TX_DATA, e.tx);
                chk("oe_data", OE_DATA, e.oe);
            end
        end
    end

    task automatic drive_dp(input logic [3:0] lvl, input logic [3:0] oe,
                            input logic [15:0] tx_exp, input logic [15:0] oe_exp);
        dp_t e;
        LANE_LVL = lvl;
        LANE_OE  = oe;
        e.cyc = cyc + 1; e.tx = tx_exp; e.oe = oe_exp;
        dp_q.push_back(e);
        @(negedge FAB_CLK);
    endtask

    // Called at a negedge; the request is sampled at the next posedge (cycle t0).
    task automatic start_adj(input logic [3:0] lane, input logic ld, input logic dr,
                             input logic [7:0] taps, output int t0);
        ADJ_LANE = lane;
        ADJ_LOAD = ld;
        ADJ_DIR  = dr;
        ADJ_TAPS = taps;
        ADJ_REQ  = 1'b1;
        t0 = cyc;
    endtask

    task automatic wait_idle();
        int i;
        @(negedge FAB_CLK);
        ADJ_REQ = 1'b0;
        for (i = 0; i < 2000; i++) begin
            if (!ADJ_BUSY) break;
            @(negedge FAB_CLK);
        end
        if (i == 2000) chk("busy_timeout", ADJ_BUSY, 1'b0);
        @(negedge FAB_CLK);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int t0;
        ARST = 1'b1;
        LANE_LVL = '0; LANE_OE = '0;
        ADJ_REQ = 1'b0; ADJ_LOAD = 1'b0; ADJ_LANE = '0; ADJ_DIR = 1'b0; ADJ_TAPS = '0;
        DELAY_LINE_OUT_OF_RANGE = '0;
        repeat (3) @(negedge FAB_CLK);

        chk("rst_tx", TX_DATA, 16'h0000);
        chk("rst_oe", OE_DATA, 16'hFFFF);
        chk("rst_tap", TAP_POS, 32'h01010101);
        chk("rst_hs", {ADJ_BUSY, ADJ_DONE, ADJ_ERR}, 3'b000);
        chk("rst_strobes", {DELAY_LINE_MOVE, DELAY_LINE_LOAD, DELAY_LINE_DIRECTION}, 12'h000);
        ARST = 1'b0;
        @(negedge FAB_CLK);

        drive_dp(4'b1010, 4'b1111, 16'hF0F0, 16'hFFFF);
        drive_dp(4'b0101, 4'b0011, 16'h0F0F, 16'h00FF);
        drive_dp(4'b1111, 4'b0000, 16'hFFFF, 16'h0000);
        @(negedge FAB_CLK);

        // Step up lane 2 by 3; a request with a bad lane mid-operation is ignored.
        start_adj(4'd2, 1'b0, 1'b1, 8'd3, t0);
        push_pulse(t0 + 2,  4'b0100, 4'b0000, 4'b0100);
        push_pulse(t0 + 7,  4'b0100, 4'b0000, 4'b0100);
        push_pulse(t0 + 12, 4'b0100, 4'b0000, 4'b0100);
        push_done(t0 + 17, 1'b0, 32'h01040101);
        @(negedge FAB_CLK);
        ADJ_REQ = 1'b0;
        chk("busy_cycle1", ADJ_BUSY, 1'b1);
        repeat (4) @(negedge FAB_CLK);
        ADJ_REQ  = 1'b1;
        ADJ_LANE = 4'd5;
        wait_idle();

        // Lane 1 up by 5, IOD reports out-of-range during the second settle.
        start_adj(4'd1, 1'b0, 1'b1, 8'd5, t0);
        push_pulse(t0 + 2, 4'b0010, 4'b0000, 4'b0010);
        push_pulse(t0 + 7, 4'b0010, 4'b0000, 4'b0010);
        push_done(t0 + 12, 1'b1, 32'h01040201);
        @(negedge FAB_CLK);
        ADJ_REQ = 1'b0;
        repeat (7) @(negedge FAB_CLK);
        DELAY_LINE_OUT_OF_RANGE = 4'b0010;
        wait_idle();
        DELAY_LINE_OUT_OF_RANGE = '0;

        // Lower bound: lane 0 from 1 down by 3 -> one pulse, then range error.
        start_adj(4'd0, 1'b0, 1'b0, 8'd3, t0);
        push_pulse(t0 + 2, 4'b0001, 4'b0000, 4'b0000);
        push_done(t0 + 7, 1'b1, 32'h01040200);
        wait_idle();

        // Already at 0: rejected in SETUP with no pulse.
        start_adj(4'd0, 1'b0, 1'b0, 8'd1, t0);
        push_done(t0 + 2, 1'b1, 32'h01040200);
        wait_idle();

        // Zero taps: clean completion with no pulse.
        start_adj(4'd1, 1'b0, 1'b1, 8'd0, t0);
        push_done(t0 + 2, 1'b0, 32'h01040200);
        wait_idle();

        // Lane 3 up by 2, then LOAD back to INIT_TAP.
        start_adj(4'd3, 1'b0, 1'b1, 8'd2, t0);
        push_pulse(t0 + 2, 4'b1000, 4'b0000, 4'b1000);
        push_pulse(t0 + 7, 4'b1000, 4'b0000, 4'b1000);
        push_done(t0 + 12, 1'b0, 32'h03040200);
        wait_idle();

        start_adj(4'd3, 1'b1, 1'b0, 8'd0, t0);
        push_pulse(t0 + 2, 4'b0000, 4'b1000, 4'b0000);
        push_done(t0 + 7, 1'b0, 32'h01040200);
        wait_idle();

        // Bad lane index: DONE+ERR at cycle 1, no strobes.
        start_adj(4'd5, 1'b0, 1'b1, 8'd2, t0);
        push_done(t0 + 1, 1'b1, 32'h01040200);
        wait_idle();

        // Upper bound: lane 2 from 4 up by 124 stops at 127 with an error.
        start_adj(4'd2, 1'b0, 1'b1, 8'd124, t0);
        for (int k = 0; k < 123; k++) push_pulse(t0 + 2 + 5 * k, 4'b0100, 4'b0000, 4'b0100);
        push_done(t0 + 617, 1'b1, 32'h017F0200);
        wait_idle();

        start_adj(4'd2, 1'b0, 1'b1, 8'd1, t0);
        push_done(t0 + 2, 1'b1, 32'h017F0200);
        wait_idle();

        // Reset mid-operation: abort with no DONE, all state back to reset values.
        start_adj(4'd1, 1'b0, 1'b1, 8'd3, t0);
        push_pulse(t0 + 2, 4'b0010, 4'b0000, 4'b0010);
        @(negedge FAB_CLK);
        ADJ_REQ = 1'b0;
        repeat (3) @(negedge FAB_CLK);
        ARST = 1'b1;
        #1;
        chk("mid_rst_busy", ADJ_BUSY, 1'b0);
        chk("mid_rst_done", ADJ_DONE, 1'b0);
        chk("mid_rst_strobes", {DELAY_LINE_MOVE, DELAY_LINE_LOAD, DELAY_LINE_DIRECTION}, 12'h000);
        chk("mid_rst_tap", TAP_POS, 32'h01010101);
        chk("mid_rst_tx", TX_DATA, 16'h0000);
        chk("mid_rst_oe", OE_DATA, 16'hFFFF);
        @(negedge FAB_CLK);
        ARST = 1'b0;
        repeat (8) @(negedge FAB_CLK);

        chk("pulse_q_drained", pulse_q.size(), 0);
        chk("done_q_drained", done_q.size(), 0);
        chk("dp_q_drained", dp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
